// File: rtl/sig_phase_timer.sv
// Phase timer for the highway/farm-road signal FSM.
// Debounces the car sensor, times each phase and strobes en/x once per phase.
module sig_phase_timer #(
  parameter int CNT_W         = 8,
  parameter int MIN_GREEN     = 16,
  parameter int MAX_FWY_GREEN = 48,
  parameter int YELLOW_TIME   = 4,
  parameter int DEBOUNCE      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             car_raw,
  input  logic [1:0]       hwy,
  input  logic [1:0]       fwy,
  output logic             en,
  output logic             x,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             car_seen,
  output logic             err
);

  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] L_Y = 2'd0;
  localparam logic [1:0] L_R = 2'd1;
  localparam logic [1:0] L_G = 2'd2;

  localparam logic [2:0] PH_HG  = 3'd0;
  localparam logic [2:0] PH_HY  = 3'd1;
  localparam logic [2:0] PH_FG  = 3'd2;
  localparam logic [2:0] PH_FY  = 3'd3;
  localparam logic [2:0] PH_ILL = 3'd4;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_T   = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_T   = CNT_W'(MAX_FWY_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_T   = CNT_W'(YELLOW_TIME - 1);
  localparam logic [DW-1:0]    DEB_MAX = DW'(DEBOUNCE);

  logic [2:0]    phase;
  logic [2:0]    prev_phase;
  logic          sync1;
  logic          sync2;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_nxt;
  logic          adv_ok;
  logic [0:0]    state;
  logic [1:0]    wait_cnt;

  always_comb begin
    phase = PH_ILL;
    unique case (1'b1)
      (hwy == L_G && fwy == L_R): phase = PH_HG;
      (hwy == L_Y && fwy == L_R): phase = PH_HY;
      (hwy == L_R && fwy == L_G): phase = PH_FG;
      (hwy == L_R && fwy == L_Y): phase = PH_FY;
      default:                    phase = PH_ILL;
    endcase
  end

  always_comb begin
    deb_nxt = '0;
    if (sync2) begin
      deb_nxt = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + DW'(1);
    end
  end

  // car_seen tracks the count as it is written, giving DEBOUNCE+2 latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      deb_cnt  <= '0;
      car_seen <= 1'b0;
    end else begin
      sync1    <= car_raw;
      sync2    <= sync1;
      deb_cnt  <= deb_nxt;
      car_seen <= (deb_nxt == DEB_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_phase <= PH_HG;
      phase_cnt  <= '0;
    end else begin
      prev_phase <= phase;
      if (phase == PH_ILL || phase != prev_phase) begin
        phase_cnt <= '0;
      end else if (phase_cnt != CNT_MAX) begin
        phase_cnt <= phase_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    adv_ok = 1'b0;
    case (phase)
      PH_HG:   adv_ok = car_seen && (phase_cnt >= MIN_T);
      PH_HY:   adv_ok = (phase_cnt >= YEL_T);
      PH_FG:   adv_ok = (!car_seen && (phase_cnt >= MIN_T))
                        || (phase_cnt >= MAX_T);
      PH_FY:   adv_ok = (phase_cnt >= YEL_T);
      default: adv_ok = 1'b0;
    endcase
  end

  // phase_cnt only belongs to the current phase once it has been seen twice
  assign en = (state == S_RUN) && (phase == prev_phase) && adv_ok;
  assign x  = en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (phase == PH_ILL) begin
        err <= 1'b1;
      end
      case (state)
        S_RUN: begin
          if (en) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (phase != prev_phase) begin
            state <= S_RUN;
          end else if (wait_cnt == 2'd3) begin
            err   <= 1'b1;
            state <= S_RUN;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
